// File: rtl/trigger_conditioner_if.sv
// rtl/trigger_conditioner_if.sv - trigger source in, conditioned trigger and status out
interface trigger_conditioner_if #(
  parameter int REJ_W = 8
);
  logic             raw_in;
  logic             enable;
  logic             trigger;
  logic             busy;
  logic [REJ_W-1:0] reject_cnt;

  modport master (
    output raw_in,
    output enable,
    input  trigger,
    input  busy,
    input  reject_cnt
  );

  modport slave (
    input  raw_in,
    input  enable,
    output trigger,
    output busy,
    output reject_cnt
  );
endinterface

// File: rtl/trigger_conditioner.sv
// rtl/trigger_conditioner.sv - synchronise, debounce and rate-limit a raw trigger into a one-cycle pulse
module trigger_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 10,
  parameter int CNT_W           = 8,
  parameter int REJ_W           = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  trigger_conditioner_if.slave  tif
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  logic                   db_level;
  logic                   db_level_q;
  logic [CNT_W-1:0]       db_cnt;
  logic                   db_rise;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       hold_q, hold_d;
  logic                   trig_q, trig_d;
  logic [REJ_W-1:0]       rej_q, rej_d;

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign db_rise = db_level & ~db_level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      db_level   <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], tif.raw_in};
      db_level_q <= db_level;
      // any cycle back at the accepted level restarts the persistence count
      if (sync_in == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync_in;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      trig_q  <= 1'b0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      trig_q  <= trig_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    trig_d  = 1'b0;
    rej_d   = rej_q;
    case (state_q)
      IDLE: begin
        if (db_rise && tif.enable) begin
          trig_d  = 1'b1;
          hold_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = IDLE;
        end
        // rejection ignores enable: the downstream pulse is still active
        if (db_rise && (rej_q != '1)) begin
          rej_d = rej_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tif.trigger    = trig_q;
  assign tif.busy       = (state_q == HOLD);
  assign tif.reject_cnt = rej_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// tb/tb_trigger_conditioner.sv - vector table plus scoreboard bench for trigger_conditioner
module tb_trigger_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic raw_v [3];
  logic en_v  [3];

  trigger_conditioner_if #(.REJ_W(8)) if_a ();
  trigger_conditioner_if #(.REJ_W(8)) if_b ();
  trigger_conditioner_if #(.REJ_W(2)) if_c ();

  assign if_a.raw_in = raw_v[0];
  assign if_a.enable = en_v[0];
  assign if_b.raw_in = raw_v[1];
  assign if_b.enable = en_v[1];
  assign if_c.raw_in = raw_v[2];
  assign if_c.enable = en_v[2];

  trigger_conditioner #(.HOLDOFF_CYCLES(10)) dut_a (.clk(clk), .rst(rst), .tif(if_a));
  trigger_conditioner #(.HOLDOFF_CYCLES(20)) dut_b (.clk(clk), .rst(rst), .tif(if_b));
  trigger_conditioner #(.HOLDOFF_CYCLES(200), .REJ_W(2)) dut_c (.clk(clk), .rst(rst), .tif(if_c));

  typedef struct {
    string name;
    string pat;
    bit    en;
    int    sel;
    int    win;
    int    exp_cnt;
    int    exp_first;
    int    exp_busy;
    int    exp_rej;
  } vec_t;

  vec_t vecs  [$];
  vec_t exp_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic string rep(input string c, input int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, c};
    return s;
  endfunction

  function automatic logic bitof(input string s, input int i);
    if (i >= s.len()) return 1'b0;
    return (s[i] == 8'h31);
  endfunction

  function automatic int get_trig(input int s);
    case (s)
      0:       return int'(if_a.trigger);
      1:       return int'(if_b.trigger);
      default: return int'(if_c.trigger);
    endcase
  endfunction

  function automatic int get_busy(input int s);
    case (s)
      0:       return int'(if_a.busy);
      1:       return int'(if_b.busy);
      default: return int'(if_c.busy);
    endcase
  endfunction

  function automatic int get_rej(input int s);
    case (s)
      0:       return int'(if_a.reject_cnt);
      1:       return int'(if_b.reject_cnt);
      default: return int'(if_c.reject_cnt);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) raw_v[i] = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Edge k is the k-th posedge after the first pattern bit is driven; outputs sampled on the following negedge.
  task automatic run_vec(input vec_t v);
    int   cnt, first, busy_n, rej;
    vec_t e;
    exp_q.push_back(v);
    do_reset();
    repeat (5) @(negedge clk);
    en_v[v.sel]  = v.en;
    raw_v[v.sel] = bitof(v.pat, 0);
    cnt = 0; first = -1; busy_n = 0;
    for (int k = 1; k <= v.win; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_trig(v.sel) != 0) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (get_busy(v.sel) != 0) busy_n++;
      raw_v[v.sel] = bitof(v.pat, k);
    end
    rej = get_rej(v.sel);
    en_v[v.sel] = 1'b1;
    e = exp_q.pop_front();
    chk({e.name, " trigger count"}, cnt, e.exp_cnt);
    chk({e.name, " first trigger edge"}, first, e.exp_first);
    chk({e.name, " busy cycles"}, busy_n, e.exp_busy);
    chk({e.name, " reject_cnt"}, rej, e.exp_rej);
  endtask

  initial begin
    int cnt, first;
    string sat;

    for (int i = 0; i < 3; i++) begin
      raw_v[i] = 1'b0;
      en_v[i]  = 1'b1;
    end

    sat = rep("1", 6);
    for (int i = 0; i < 5; i++) sat = {sat, rep("0", 6), rep("1", 6)};

    //          name              pattern                                            en sel win cnt first busy rej
    vecs.push_back('{"clean",      rep("1", 40),                                      1, 0, 64,  1, 7,  10,  0});
    vecs.push_back('{"bounce",     {"110110110", rep("1", 40)},                       1, 0, 64,  1, 16, 10,  0});
    vecs.push_back('{"enable0",    rep("1", 40),                                      0, 0, 64,  0, -1, 0,   0});
    vecs.push_back('{"two_free",   {rep("1", 7), rep("0", 13), rep("1", 20)},         1, 0, 64,  2, 7,  20,  0});
    vecs.push_back('{"p7r6_h10",   {rep("1", 7), rep("0", 6), rep("1", 30)},          1, 0, 64,  2, 7,  20,  0});
    vecs.push_back('{"p7r6_h20",   {rep("1", 7), rep("0", 6), rep("1", 30)},          1, 1, 64,  1, 7,  20,  1});
    vecs.push_back('{"first_free", {rep("1", 7), rep("0", 4), rep("1", 30)},          1, 0, 64,  2, 7,  20,  0});
    vecs.push_back('{"saturate",   sat,                                               1, 2, 240, 1, 7,  200, 3});
    vecs.push_back('{"last_hold",  {rep("1", 6), rep("0", 4), rep("1", 30)},          1, 0, 64,  1, 7,  10,  1});

    // Outputs while reset is held
    repeat (3) @(negedge clk);
    chk("reset trigger", get_trig(0), 0);
    chk("reset busy", get_busy(0), 0);
    chk("reset reject_cnt", get_rej(0), 0);
    chk("reset reject_cnt narrow", get_rej(2), 0);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset mid-holdoff with raw_in kept high; last_hold left reject_cnt at 1
    raw_v[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre-reset reject_cnt", get_rej(0), 1);
    raw_v[0] = 1'b1;
    repeat (11) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("busy at hold_cnt 4", get_busy(0), 1);
    #2 rst = 1'b0;
    #1;
    chk("async reset trigger", get_trig(0), 0);
    chk("async reset busy", get_busy(0), 0);
    chk("async reset reject_cnt", get_rej(0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0; first = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_trig(0) != 0) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    chk("post-reset trigger count", cnt, 1);
    chk("post-reset trigger edge", first, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
